// File: rtl/icache_refill_if.sv
// Bundle of the icache miss port and the instruction-memory read port seen by the refill unit.
// slave = refill unit view, master = cache/memory environment view.
interface icache_refill_if #(
    parameter int CNT_W = 16
);
    logic             miss_req;
    logic [31:0]      miss_addr;
    logic [127:0]     line_data;
    logic [31:0]      line_addr;
    logic             line_ready;
    logic             busy;
    logic             mem_rd;
    logic [31:0]      mem_addr;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] refill_cnt;

    modport slave (
        input  miss_req, miss_addr, mem_ack, mem_rdata,
        output line_data, line_addr, line_ready, busy, mem_rd, mem_addr, refill_cnt
    );

    modport master (
        output miss_req, miss_addr, mem_ack, mem_rdata,
        input  line_data, line_addr, line_ready, busy, mem_rd, mem_addr, refill_cnt
    );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache miss service: fetches a 4-word line one word per memory handshake,
// returns it with a one-cycle ready pulse and counts completed refills (saturating).
module icache_refill #(
    parameter int WORDS = 4,
    parameter int CNT_W = 16
) (
    input logic            clk_i,
    input logic            rst_ni,
    icache_refill_if.slave bus
);
    localparam int         LINE_W = 32 * WORDS;
    localparam logic [1:0] LAST   = 2'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE, HOLD} state_e;

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [LINE_W-1:0]  line_data_q, line_data_d;
    logic [31:0]        line_addr_q, line_addr_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]   refill_cnt_q, refill_cnt_d;
    logic               mem_rd_q, mem_rd_d;
    logic               busy_q, busy_d;
    logic               line_ready_q, line_ready_d;
    logic [31:0]        base;
    logic               unused_offset;

    assign base          = {bus.miss_addr[31:4], 4'h0};
    assign unused_offset = ^bus.miss_addr[3:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_data_d  = line_data_q;
        line_addr_d  = line_addr_q;
        mem_addr_d   = mem_addr_q;
        refill_cnt_d = refill_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.miss_req) begin
                    state_d     = REQ;
                    line_addr_d = base;
                    mem_addr_d  = base;
                    cnt_d       = 2'd0;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (cnt_q == 2'(i)) line_data_d[32*i +: 32] = bus.mem_rdata;
                    end
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        // Only the word-select bits step, so a line never carries into [31:4].
                        mem_addr_d[3:2] = mem_addr_q[3:2] + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = HOLD;
                if (refill_cnt_q != {CNT_W{1'b1}}) refill_cnt_d = refill_cnt_q + 1'b1;
            end
            HOLD: begin
                // The cache keeps miss_req up until it sees line_ready; wait for it to drop.
                if (!bus.miss_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mem_rd_d     = (state_d == REQ);
        busy_d       = (state_d != IDLE);
        line_ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            line_data_q  <= '0;
            line_addr_q  <= '0;
            mem_addr_q   <= '0;
            refill_cnt_q <= '0;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            line_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_data_q  <= line_data_d;
            line_addr_q  <= line_addr_d;
            mem_addr_q   <= mem_addr_d;
            refill_cnt_q <= refill_cnt_d;
            mem_rd_q     <= mem_rd_d;
            busy_q       <= busy_d;
            line_ready_q <= line_ready_d;
        end
    end

    assign bus.line_data  = line_data_q;
    assign bus.line_addr  = line_addr_q;
    assign bus.line_ready = line_ready_q;
    assign bus.busy       = busy_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.refill_cnt = refill_cnt_q;
endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill: a word-count model of the refill protocol is checked
// against two DUTs (16-bit and 2-bit refill counters) on every cycle, plus directed literal checks.
module tb_icache_refill;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    icache_refill_if #(.CNT_W(16)) bus ();
    icache_refill_if #(.CNT_W(2))  bus2 ();

    icache_refill #(.WORDS(4), .CNT_W(16)) dut  (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
    icache_refill #(.WORDS(4), .CNT_W(2))  dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2.slave));

    assign bus2.miss_req  = bus.miss_req;
    assign bus2.miss_addr = bus.miss_addr;
    assign bus2.mem_ack   = bus.mem_ack;
    assign bus2.mem_rdata = bus.mem_rdata;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural model: words fetched so far, whether the line is being returned, refill count.
    logic        m_busy;
    logic        m_ready;
    int          m_words;
    int          m_count;
    logic [31:0] m_base;
    logic [31:0] m_line [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_words <= 0;
            m_count <= 0;
            m_base  <= 32'h0;
            for (int i = 0; i < 4; i++) m_line[i] <= 32'h0;
        end else if (m_ready) begin
            m_ready <= 1'b0;
            m_count <= m_count + 1;
        end else if (!m_busy) begin
            if (bus.miss_req === 1'b1) begin
                m_busy  <= 1'b1;
                m_base  <= {bus.miss_addr[31:4], 4'h0};
                m_words <= 0;
            end
        end else if (m_words < 4) begin
            if (bus.mem_ack === 1'b1) begin
                m_line[m_words] <= bus.mem_rdata;
                m_words         <= m_words + 1;
                if (m_words == 3) m_ready <= 1'b1;
            end
        end else if (bus.miss_req === 1'b0) begin
            m_busy <= 1'b0;
        end
    end

    logic          exp_rd;
    logic [127:0]  exp_line;
    logic [31:0]   exp_maddr;
    logic [15:0]   exp_cnt16;
    logic [1:0]    exp_cnt2;
    always_comb begin
        exp_rd    = m_busy && (m_words < 4) && !m_ready;
        exp_line  = {m_line[3], m_line[2], m_line[1], m_line[0]};
        exp_maddr = m_base + 32'(4 * m_words);
        exp_cnt16 = (m_count > 65535) ? 16'hFFFF : 16'(m_count);
        exp_cnt2  = (m_count > 3) ? 2'd3 : 2'(m_count);
    end

    always @(negedge clk) begin
        check("line_ready", bus.line_ready, m_ready);
        check("busy", bus.busy, m_busy);
        check("mem_rd", bus.mem_rd, exp_rd);
        if (exp_rd) check("mem_addr", bus.mem_addr, exp_maddr);
        check("line_data", bus.line_data, exp_line);
        check("line_addr", bus.line_addr, m_base);
        check("refill_cnt", bus.refill_cnt, exp_cnt16);
        check("line_ready2", bus2.line_ready, m_ready);
        check("busy2", bus2.busy, m_busy);
        check("mem_rd2", bus2.mem_rd, exp_rd);
        if (exp_rd) check("mem_addr2", bus2.mem_addr, exp_maddr);
        check("line_data2", bus2.line_data, exp_line);
        check("line_addr2", bus2.line_addr, m_base);
        check("refill_cnt2", bus2.refill_cnt, exp_cnt2);
    end

    // Memory responder: per-word wait gaps from a queue (or random), optional spurious acks.
    int          gap_q[$];
    logic [31:0] data_q[$];
    logic [31:0] ack_addr_q[$];
    bit          rand_gaps = 1'b0;
    bit          spur_en   = 1'b0;
    bit          word_started = 1'b0;
    int          wait_left = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
            word_started  = 1'b0;
        end else if (bus.mem_rd) begin
            if (!word_started) begin
                word_started = 1'b1;
                if (gap_q.size() > 0) wait_left = gap_q.pop_front();
                else if (rand_gaps)   wait_left = int'($urandom_range(0, 3));
                else                  wait_left = 0;
            end
            if (wait_left == 0) begin
                bus.mem_ack = 1'b1;
                if (data_q.size() > 0) bus.mem_rdata = data_q.pop_front();
                else                   bus.mem_rdata = $urandom;
                ack_addr_q.push_back(bus.mem_addr);
                word_started = 1'b0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            word_started  = 1'b0;
            bus.mem_ack   = spur_en && ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;
        end
    end

    logic [1:0] sat_q[$];

    task automatic do_refill(input logic [31:0] addr, input int hold, input bit scramble,
                             output int edges);
        bit done = 1'b0;
        bus.miss_req  = 1'b1;
        bus.miss_addr = addr;
        edges = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.line_ready) done = 1'b1;
            else if (scramble) bus.miss_addr = $urandom;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL refill_timeout: got no line_ready want line_ready within 300 cycles");
        end
        @(negedge clk);
        sat_q.push_back(bus2.refill_cnt);
        for (int h = 0; h < hold; h++) begin
            check("stale_busy", bus.busy, 1'b1);
            check("stale_mem_rd", bus.mem_rd, 1'b0);
            @(negedge clk);
        end
        bus.miss_req = 1'b0;
        @(negedge clk);
        check("release_busy", bus.busy, 1'b0);
    endtask

    task automatic check_addrs(input logic [31:0] base, input string name);
        check({name, "_count"}, 128'(ack_addr_q.size()), 128'd4);
        for (int i = 0; i < 4 && i < ack_addr_q.size(); i++)
            check(name, ack_addr_q[i], base + 32'(4 * i));
    endtask

    logic [31:0] a_words [4];
    logic [1:0]  sat_exp [5];
    int          edges;

    initial begin
        a_words[0] = 32'hA0A0_0000; a_words[1] = 32'hA1A1_1111;
        a_words[2] = 32'hA2A2_2222; a_words[3] = 32'hA3A3_3333;
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        bus.miss_req  = 1'b0;
        bus.miss_addr = 32'h0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_line_ready", bus.line_ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_rd", bus.mem_rd, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_line_data", bus.line_data, 128'h0);
        check("rst_refill_cnt", bus.refill_cnt, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait refill
        for (int i = 0; i < 4; i++) begin data_q.push_back(a_words[i]); gap_q.push_back(0); end
        ack_addr_q.delete();
        do_refill(32'h0040_002C, 0, 1'b0, edges);
        check("zw_latency", 128'(edges), 128'd5);
        check_addrs(32'h0040_0020, "zw_addr");
        check("zw_line_data", bus.line_data,
              {32'hA3A3_3333, 32'hA2A2_2222, 32'hA1A1_1111, 32'hA0A0_0000});
        check("zw_line_addr", bus.line_addr, 32'h0040_0020);
        check("zw_refill_cnt", bus.refill_cnt, 16'd1);

        // Wait states 0,3,1,2
        gap_q = '{0, 3, 1, 2};
        do_refill(32'h1234_5678, 0, 1'b0, edges);
        check("ws_latency", 128'(edges), 128'd11);

        // Stale request held 5 cycles after line_ready
        do_refill(32'h0000_1000, 5, 1'b0, edges);

        // Wrap at top of memory with spurious acks outside REQ
        spur_en = 1'b1;
        ack_addr_q.delete();
        do_refill(32'hFFFF_FFF4, 2, 1'b0, edges);
        check_addrs(32'hFFFF_FFF0, "wrap_addr");
        check("wrap_line_addr", bus.line_addr, 32'hFFFF_FFF0);
        repeat (6) @(negedge clk);
        check("spur_refill_cnt", bus.refill_cnt, 16'd4);

        do_refill(32'h8000_0040, 0, 1'b0, edges);
        for (int i = 0; i < 5; i++) check("sat_cnt", sat_q[i], sat_exp[i]);
        spur_en = 1'b0;

        // Reset mid-refill after two acks
        gap_q.delete();
        @(negedge clk);
        bus.miss_req  = 1'b1;
        bus.miss_addr = 32'h0070_0000;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mem_rd", bus.mem_rd, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_line_data", bus.line_data, 128'h0);
        check("mid_rst_line_addr", bus.line_addr, 32'h0);
        check("mid_rst_mem_addr", bus.mem_addr, 32'h0);
        check("mid_rst_refill_cnt", bus.refill_cnt, 16'h0);
        bus.miss_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ack_addr_q.delete();
        do_refill(32'h0040_0010, 0, 1'b0, edges);
        check_addrs(32'h0040_0010, "post_rst_addr");
        check("post_rst_refill_cnt", bus.refill_cnt, 16'd1);

        // Randomized refills: wait gaps, spurious acks, address churn after acceptance
        rand_gaps = 1'b1;
        spur_en   = 1'b1;
        for (int n = 0; n < 40; n++) begin
            do_refill($urandom, int'($urandom_range(0, 3)), 1'b1, edges);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check("rand_refill_cnt", bus.refill_cnt, 16'd41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-service stage directly downstream of the instruction cache. On a cache read miss it fetches the four 32-bit words of the missing 16-byte line from main memory, one word per handshake, assembles them into a 128-bit line, and returns the line to the cache with a one-cycle ready pulse. It sits between the icache miss port and the instruction-memory read port.

## Interface
- WORDS, 4, words per line (fixed; line is 128 bits)
- CNT_W, 16, width of the refill performance counter
- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- miss_req  in  1  cache read-miss request, level, held until line_ready seen
- miss_addr  in  32  missing instruction address; only bits [31:4] used
- line_data  out  128  assembled line; word i at bits [32i+31:32i]
- line_addr  out  32  line base address {miss_addr[31:4],4'b0} of the last refill
- line_ready  out  1  one-cycle pulse: line_data/line_addr valid
- busy  out  1  high from request acceptance until return to IDLE
- mem_rd  out  1  memory read request, level
- mem_addr  out  32  word address for current read
- mem_ack  in  1  one-cycle pulse; mem_rdata valid, current mem_addr consumed
- mem_rdata  in  32  read word
- refill_cnt  out  CNT_W  completed refills, saturating

## Operation
- Reset (Rst low, async): state IDLE; line_data=0, line_addr=0, line_ready=0, busy=0, mem_rd=0, mem_addr=0, refill_cnt=0, word counter=0. Takes effect immediately, including mid-refill; partial line discarded, mem_rd drops at once.
- States: IDLE, REQ, DONE, HOLD.
- IDLE: if miss_req=1 at an edge -> REQ; latch base={miss_addr[31:4],4'b0} into line_addr and mem_addr; mem_rd=1; busy=1; word counter=0. mem_ack ignored.
- REQ: mem_rd=1. On edge with mem_ack=1: line_data[32*cnt+:32] <= mem_rdata; if cnt<3: cnt+1, mem_addr+4, stay REQ; if cnt==3: mem_rd=0, -> DONE. No ack: hold all.
- DONE: line_ready=1 for exactly this cycle; refill_cnt+1 (saturate at all-ones) on exit edge; -> HOLD.
- HOLD: busy=1; wait until miss_req=0, then -> IDLE (busy=0). Prevents a stale miss_req from re-triggering a refill of the same line.
- miss_addr changes after acceptance are ignored until next IDLE acceptance.
- Address arithmetic: only mem_addr[3:2] increments; base 0xFFFFFFF0 yields F0,F4,F8,FC with no carry into [31:4].
- line_data and line_addr hold their last values until overwritten by the next refill (not cleared on line_ready fall).
- mem_ack while mem_rd=0 (IDLE, DONE, HOLD): ignored, no state change.

## Timing
- All outputs registered; Moore outputs from state/regs.
- Edge E0 samples miss_req=1 -> mem_rd, busy, mem_addr=base valid after E0.
- Each mem_ack edge captures one word; back-to-back acks on consecutive edges allowed; next mem_addr valid the cycle after each ack.
- Zero-wait memory (ack every cycle E1..E4): line_ready high in cycle after E4, low after E5. Latency miss_req-sample to line_ready = 4 + total wait cycles + 1 edges.
- Minimum refill-to-refill: miss_req must be low for ≥1 edge in HOLD before a new request is accepted.

## Test plan
- Reset: Rst low mid-REQ after 2 acks -> all outputs 0 immediately, state IDLE; after release, fresh miss to 0x00400010 refills from 0x00400010.
- Zero-wait refill: miss_addr=0x0040002C, mem_rdata=A0,A1,A2,A3 acked every cycle -> mem_addr 0x20,0x24,0x28,0x2C, line_data={A3,A2,A1,A0}, line_addr=0x00400020, line_ready 1 cycle after 4th ack, refill_cnt=1.
- Wait states: ack gaps of 0,3,1,2 cycles -> mem_addr/mem_rd held during gaps, line_ready exactly 1 cycle, 11 edges E0-to-line_ready.
- Stale request: miss_req held high 5 cycles after line_ready -> no second mem_rd, busy stays 1 until miss_req falls, then IDLE.
- Wrap and spurious ack: miss_addr=0xFFFFFFF4 -> addresses 0xFFFFFFF0..FC; mem_ack pulses in IDLE/HOLD produce no capture or count change.
- Counter saturation: CNT_W=2, five refills -> refill_cnt 1,2,3,3,3.
